// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter: per-output-port switch allocator and link sequencer.
// Round-robin grant among cw/ccw/pe for the VC matching the current polarity,
// while the buffer of the opposite VC is offered on the link.
module ring_output_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,        // asynchronous, active low
  input  logic [NREQ-1:0] req_even,
  input  logic [NREQ-1:0] req_odd,
  input  logic            ro,
  output logic            polarity,
  output logic [NREQ-1:0] grant,
  output logic            so,
  output logic            send_vc,
  output logic            ob_full_even,
  output logic            ob_full_odd
);

  logic       polarity_q, polarity_d;
  logic [1:0] rr_even_q, rr_even_d;
  logic [1:0] rr_odd_q, rr_odd_d;
  logic       full_even_q, full_even_d;
  logic       full_odd_q, full_odd_d;

  logic [NREQ-1:0] req_sel;
  logic [NREQ-1:0] grant_c;
  logic            full_sel;
  logic [1:0]      ptr_sel;
  logic [1:0]      idx;
  logic [1:0]      gnt_idx;
  logic            gnt_valid;
  logic            so_c;

  // Increment modulo 3; the unused code 3 folds back to 0.
  function automatic logic [1:0] inc3(input logic [1:0] p);
    inc3 = (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Switch phase: search ptr, ptr+1, ptr+2 (mod 3) among requests of VC = polarity.
  always_comb begin
    grant_c   = '0;
    gnt_idx   = 2'd0;
    gnt_valid = 1'b0;
    req_sel   = polarity_q ? req_odd : req_even;
    full_sel  = polarity_q ? full_odd_q : full_even_q;
    ptr_sel   = polarity_q ? rr_odd_q : rr_even_q;
    idx       = (ptr_sel == 2'd3) ? 2'd0 : ptr_sel;
    if (reset && !full_sel) begin
      for (int k = 0; k < 3; k++) begin
        if (!gnt_valid && req_sel[idx]) begin
          gnt_valid    = 1'b1;
          gnt_idx      = idx;
          grant_c[idx] = 1'b1;
        end
        idx = inc3(idx);
      end
    end
  end

  // Link phase: the buffer of VC = ~polarity is offered; reset low forces so off.
  always_comb begin
    so_c = reset & (polarity_q ? full_even_q : full_odd_q);
  end

  // Next state: polarity toggle, pointer advance on grant, full-flag set/clear.
  always_comb begin
    polarity_d  = ~polarity_q;
    rr_even_d   = rr_even_q;
    rr_odd_d    = rr_odd_q;
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    if (!polarity_q) begin
      // even switch phase, odd link phase
      if (gnt_valid) begin
        rr_even_d   = inc3(gnt_idx);
        full_even_d = 1'b1;
      end
      if (so_c && ro) begin
        full_odd_d = 1'b0;
      end
    end else begin
      // odd switch phase, even link phase
      if (gnt_valid) begin
        rr_odd_d   = inc3(gnt_idx);
        full_odd_d = 1'b1;
      end
      if (so_c && ro) begin
        full_even_d = 1'b0;
      end
    end
  end

  // State registers; reset drops held flits and restarts on an even cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_q  <= 1'b0;
      rr_even_q   <= 2'd0;
      rr_odd_q    <= 2'd0;
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
    end else begin
      polarity_q  <= polarity_d;
      rr_even_q   <= rr_even_d;
      rr_odd_q    <= rr_odd_d;
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
    end
  end

  assign polarity     = polarity_q;
  assign grant        = grant_c;
  assign so           = so_c;
  assign send_vc      = ~polarity_q;
  assign ob_full_even = full_even_q;
  assign ob_full_odd  = full_odd_q;

endmodule

// File: doc/ring_output_arbiter.md
# ring_output_arbiter

Per-output-port switch allocator and link sequencer for the bidirectional-ring router. Each router instantiates three: the cw, ccw and pe output ports. Each instance does two things. It arbitrates round-robin among the three input channels (cw, ccw, pe) that hold a flit destined for its port. It also sequences the even/odd virtual-channel output buffers against a global polarity bit: one VC is switched into its output buffer while the other VC is transmitted on the link. The 64-bit datapath muxes and buffers live in the router; this block only produces selects, load strobes and link handshakes.

## Interface
- NREQ, 3: number of requesting input channels. Bit 0 = cw, 1 = ccw, 2 = pe. Logic is written for exactly 3.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_even  input  NREQ  input channel i holds an even-VC flit routed to this port
- req_odd  input  NREQ  input channel i holds an odd-VC flit routed to this port
- ro  input  1  downstream ready: link receiver can accept a flit this cycle
- polarity  output  1  cycle parity; 0 = even cycle
- grant  output  NREQ  one-hot switch grant, combinational, valid in current cycle; the datapath loads the granted flit into the output buffer of VC = polarity at the next edge
- so  output  1  send valid on link, combinational
- send_vc  output  1  which output buffer drives the link data (= ~polarity)
- ob_full_even  output  1  even output buffer occupied
- ob_full_odd  output  1  odd output buffer occupied

## Operation
- Polarity:
  - Register, reset 0, toggles every clk after reset deassertion.
- Switch phase, VC = polarity:
  - If the selected buffer's full flag is 0 and req_<VC> is nonzero, grant exactly one requester.
  - Otherwise grant = 000.
- Arbitration:
  - Separate 2-bit round-robin pointers rr_even and rr_odd, legal values 0..2, reset 0.
  - Search order is ptr, ptr+1, ptr+2, all mod 3.
  - After a grant to channel i, that VC's pointer becomes (i+1) mod 3, so 2 wraps to 0.
  - The pointer is unchanged on cycles with no grant.
  - The other VC's pointer is never touched.
- Grant effect:
  - At the edge, the full flag of VC = polarity sets to 1.
  - The granted input channel deasserts its request in the following cycle; that is the datapath's responsibility.
- Link phase, VC = ~polarity:
  - so = full flag of ~polarity.
  - On an edge with so && ro, that full flag clears.
  - With ro = 0, the flag holds and the flit waits for the next cycle of the same parity, two cycles later.
- No buffer conflicts:
  - Switch and link phases always target different buffers in the same cycle, so no simultaneous set/clear on one flag exists.
- Resulting per-flit timing: a flit switched into VC v can be sent at the earliest in the very next cycle.
- Illegal input: req bits outside NREQ are ignored. req and ro are sampled only in their own phase.

## Timing
- Reset values, applied immediately and asynchronously on reset low:
  - polarity = 0, rr_even = rr_odd = 0, ob_full_even = ob_full_odd = 0.
  - grant = 000 and so = 0 while reset is low. Both are forced combinationally.
- Reset mid-operation: held flits are dropped, all flags clear, and pointers return to 0. The first cycle after release is even.
- Latencies:
  - Request to grant: 0 cycles, combinational, but only in the matching-parity cycle. Worst case 1 extra cycle of parity wait.
  - Grant to so: 1 cycle when ro = 1.
- Throughput: each VC completes at most one flit per 2 cycles; the port completes at most one flit per cycle overall.
- Fairness: any continuously asserted request is granted within 3 grants of its VC.

## Test plan
- Reset and polarity: hold reset low for 3 cycles with req_even = 111 and ro = 1.
  - During reset: grant = 000, so = 0, both flags 0.
  - After release: polarity sequence 0,1,0,1.
- Round-robin on one VC: req_even = 111 held, req_odd = 000, ro = 1.
  - Even-cycle grants are 001, 010, 100, 001.
  - Each grant is followed by so = 1 with send_vc = 0 on the next odd cycle.
  - ob_full_even is 1 only during those odd cycles.
- Backpressure: one even grant, then ro = 0 for 4 cycles.
  - ob_full_even stays 1 and so stays 1 on odd cycles.
  - No even grant is issued despite req_even = 010.
  - Raise ro on an odd cycle: flag clears, and the next even cycle grants 010.
- Independent pointers: req_even = 011 and req_odd = 110, both held, ro = 1.
  - Even grants alternate 001, 010.
  - Odd grants alternate 010, 100.
  - Neither pointer is disturbed by the other VC.
- Wrap and single requester: rr_even = 0 and req_even = 100.
  - grant = 100 and rr_even becomes 0.
  - Next, req_even = 011 gives grant = 001.
- Reset mid-operation: assert reset with ob_full_odd = 1 and so = 1, mid-cycle.
  - so drops and the flag clears within the same cycle, before the next edge.
  - After release: pointers 0 and polarity 0.
